// File: rtl/escaner_filas.sv
// Row-driving 4x4 keypad scanner: walks a one-hot row, debounces press and
// release, and emits one {row,col} code per keypress with a one-cycle strobe.
module escaner_filas #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk_Teclado,
  input  logic       rst_n,
  input  logic [3:0] Columna,
  output logic [3:0] Fila,
  output logic [7:0] cod,
  output logic       cod_valid,
  output logic       key_down
);

  localparam int            PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_N    = 4'(DEBOUNCE);

  typedef enum logic [2:0] {IDLE, SCAN, DEB, EMIT, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] pre_reg;
  logic          tick;
  logic          col_onehot;
  logic [3:0]    fila_reg, fila_next;
  logic [3:0]    row_reg, row_next;
  logic [3:0]    col_reg, col_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [3:0]    rcnt_reg, rcnt_next;
  logic [7:0]    cod_reg, cod_next;
  logic          cod_valid_reg, key_down_reg;

  assign tick       = (pre_reg == DIV_LAST);
  assign col_onehot = (Columna != 4'd0) && ((Columna & (Columna - 4'd1)) == 4'd0);

  always_ff @(posedge clk_Teclado or negedge rst_n) begin
    if (!rst_n) pre_reg <= '0;
    else        pre_reg <= tick ? '0 : pre_reg + 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    fila_next  = fila_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    cnt_next   = cnt_reg;
    rcnt_next  = rcnt_reg;
    case (state_reg)
      IDLE: begin
        fila_next = 4'b1111;
        if (tick && col_onehot) begin
          state_next = SCAN;
          fila_next  = 4'b1000;
        end
      end
      SCAN: begin
        if (tick) begin
          if (col_onehot) begin
            row_next   = fila_reg;
            col_next   = Columna;
            cnt_next   = 4'd1;
            state_next = (DEBOUNCE == 1) ? EMIT : DEB;
          end else if (fila_reg == 4'b0001) begin
            state_next = IDLE;
            fila_next  = 4'b1111;
          end else begin
            fila_next = fila_reg >> 1;
          end
        end
      end
      DEB: begin
        if (tick) begin
          if (Columna == col_reg) begin
            cnt_next = (cnt_reg >= DEB_N) ? DEB_N : cnt_reg + 4'd1;
            if (cnt_next == DEB_N) state_next = EMIT;
          end else begin
            state_next = IDLE;
            fila_next  = 4'b1111;
          end
        end
      end
      EMIT: begin
        state_next = HOLD;
        rcnt_next  = 4'd0;
      end
      HOLD: begin
        if (tick) begin
          if (Columna == 4'd0) rcnt_next = (rcnt_reg >= DEB_N) ? DEB_N : rcnt_reg + 4'd1;
          else                 rcnt_next = 4'd0;
          if (rcnt_next == DEB_N) begin
            state_next = IDLE;
            fila_next  = 4'b1111;
          end
        end
      end
      default: begin
        state_next = IDLE;
        fila_next  = 4'b1111;
      end
    endcase
  end

  // Code is captured on the transition into EMIT so the strobe lands in the EMIT cycle.
  always_comb begin
    cod_next = cod_reg;
    if (state_next == EMIT) cod_next = {row_next, col_next};
  end

  always_ff @(posedge clk_Teclado or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      fila_reg      <= 4'b1111;
      row_reg       <= 4'd0;
      col_reg       <= 4'd0;
      cnt_reg       <= 4'd0;
      rcnt_reg      <= 4'd0;
      cod_reg       <= 8'd0;
      cod_valid_reg <= 1'b0;
      key_down_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fila_reg      <= fila_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      cnt_reg       <= cnt_next;
      rcnt_reg      <= rcnt_next;
      cod_reg       <= cod_next;
      cod_valid_reg <= (state_next == EMIT);
      key_down_reg  <= (state_next == EMIT) || (state_next == HOLD);
    end
  end

  assign Fila      = fila_reg;
  assign cod       = cod_reg;
  assign cod_valid = cod_valid_reg;
  assign key_down  = key_down_reg;

endmodule

// File: tb/tb_escaner_filas.sv
// Bench for escaner_filas: a procedural keypad/scanner model runs alongside the
// DUT and every cycle is compared, plus directed checks on codes and timing.
module tb_escaner_filas;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Columna;
  logic [3:0] Fila;
  logic [7:0] cod;
  logic       cod_valid;
  logic       key_down;

  escaner_filas #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk_Teclado(clk),
    .rst_n      (rst_n),
    .Columna    (Columna),
    .Fila       (Fila),
    .cod        (cod),
    .cod_valid  (cod_valid),
    .key_down   (key_down)
  );

  always #5 clk = ~clk;

  // Physical keypad: up to two pressed keys, or a forced column pattern.
  logic       k_on  [2];
  logic [3:0] k_row [2];
  logic [3:0] k_col [2];
  logic       ov_en;
  logic [3:0] ov_col;

  always_comb begin
    Columna = 4'h0;
    if (ov_en) Columna = ov_col;
    else for (int i = 0; i < 2; i++)
      if (k_on[i] && ((Fila & k_row[i]) != 4'h0)) Columna = Columna | k_col[i];
  end

  function automatic logic [3:0] col_now(input logic [3:0] f);
    logic [3:0] c = 4'h0;
    if (ov_en) return ov_col;
    for (int i = 0; i < 2; i++)
      if (k_on[i] && ((f & k_row[i]) != 4'h0)) c = c | k_col[i];
    return c;
  endfunction

  function automatic bit onehot(input logic [3:0] c);
    return $countones(c) == 1;
  endfunction

  // Reference model state
  int         pcnt;
  int         m_ticks;
  int         m_phase;   // 0 idle, 1 scan, 2 debounce, 4 emit, 3 hold
  bit         abort;
  logic [3:0] m_fila;
  logic [7:0] m_cod;
  logic       m_valid;
  logic       m_kd;

  task automatic step(output bit t);
    @(posedge clk);
    t = 1'b0;
    if (!rst_n) begin
      abort = 1'b1; pcnt = 0; m_phase = 0;
      m_fila = 4'hF; m_cod = 8'h00; m_valid = 1'b0; m_kd = 1'b0;
    end else begin
      t    = (pcnt == SCAN_DIV - 1);
      pcnt = (pcnt + 1) % SCAN_DIV;
      if (t) m_ticks++;
    end
  endtask

  task automatic wait_tick();
    bit t;
    do step(t); while (!t && !abort);
  endtask

  initial begin : model
    bit t;
    bit found;
    int n;
    logic [3:0] c, mrow, mcol;
    pcnt = 0; m_ticks = 0; abort = 1'b0; m_phase = 0;
    m_fila = 4'hF; m_cod = 8'h00; m_valid = 1'b0; m_kd = 1'b0;
    mrow = 4'h0; mcol = 4'h0;
    forever begin
      abort = 1'b0; m_phase = 0; m_fila = 4'hF; found = 1'b0;
      while (!abort && !found) begin
        step(t);
        if (!abort && t && onehot(col_now(m_fila))) found = 1'b1;
      end
      if (abort) continue;
      m_phase = 1; m_fila = 4'b1000; found = 1'b0;
      while (!abort && !found) begin
        wait_tick();
        if (!abort) begin
          c = col_now(m_fila);
          if (onehot(c)) begin found = 1'b1; mrow = m_fila; mcol = c; end
          else if (m_fila == 4'b0001) break;
          else m_fila = m_fila >> 1;
        end
      end
      if (abort || !found) continue;
      m_phase = 2; m_fila = mrow; n = 1;
      while (!abort && n < DEBOUNCE) begin
        wait_tick();
        if (!abort) begin
          if (col_now(m_fila) == mcol) n++;
          else break;
        end
      end
      if (abort || n < DEBOUNCE) continue;
      m_phase = 4; m_cod = {mrow, mcol}; m_valid = 1'b1; m_kd = 1'b1;
      step(t);
      m_valid = 1'b0;
      if (abort) continue;
      m_phase = 3; n = 0;
      while (!abort && n < DEBOUNCE) begin
        wait_tick();
        if (!abort) n = (col_now(m_fila) == 4'h0) ? n + 1 : 0;
      end
      m_kd = 1'b0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int dut_strobes = 0;
  bit started = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int p, input int budget);
    int k = 0;
    while (m_phase != p && k < budget) begin @(negedge clk); k++; end
    check($sformatf("wait_phase%0d", p), 32'(m_phase == p), 32'd1);
  endtask

  task automatic wait_ticks(input int k);
    int t0 = m_ticks;
    int b  = 0;
    while (m_ticks < t0 + k && b < 200) begin @(negedge clk); b++; end
    check("wait_ticks", 32'(m_ticks >= t0 + k), 32'd1);
  endtask

  task automatic press(input int i, input logic [3:0] r, input logic [3:0] c);
    k_row[i] = r; k_col[i] = c; k_on[i] = 1'b1;
  endtask

  task automatic release_all();
    k_on[0] = 1'b0; k_on[1] = 1'b0;
  endtask

  initial begin
    int s0, n, lat_exp;
    logic [3:0] r, c, r2, c2;
    rst_n = 1'b0; ov_en = 1'b0; ov_col = 4'h0;
    for (int i = 0; i < 2; i++) begin k_on[i] = 1'b0; k_row[i] = 4'h0; k_col[i] = 4'h0; end
    fork
      forever begin
        @(negedge clk);
        if (rst_n && started) begin
          check("cycle", 32'({Fila, cod, cod_valid, key_down}), 32'({m_fila, m_cod, m_valid, m_kd}));
          if (cod_valid) begin
            dut_strobes++;
            $display("[TB] t=%0t strobe cod=%h", $time, cod);
          end
        end
      end
      begin
        cyc(3);
        check("rst_fila", 32'(Fila), 32'hF);
        check("rst_cod", 32'(cod), 32'h0);
        check("rst_flags", 32'({cod_valid, key_down}), 32'h0);
        #2 rst_n = 1'b1;
        started = 1'b1;
        cyc(6);

        // clean press row 0100 col 0010
        s0 = dut_strobes;
        press(0, 4'b0100, 4'b0010);
        cyc(40);
        check("clean_cod", 32'(cod), 32'h42);
        check("clean_kd", 32'(key_down), 32'd1);
        check("clean_strobes", 32'(dut_strobes - s0), 32'd1);
        release_all();
        wait_phase(0, 100);
        cyc(2);
        check("clean_idle", 32'({Fila, key_down}), 32'({4'hF, 1'b0}));

        // reset mid-scan on a row-0001 key, then restart from idle
        press(0, 4'b0001, 4'b1000);
        wait_phase(1, 40);
        cyc(SCAN_DIV + 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_fila", 32'(Fila), 32'hF);
        check("midrst_cod", 32'(cod), 32'h0);
        check("midrst_flags", 32'({cod_valid, key_down}), 32'h0);
        cyc(3);
        #2 rst_n = 1'b1;
        s0 = dut_strobes;
        cyc(50);
        check("rst_restart_cod", 32'(cod), 32'h18);
        check("rst_restart_strobes", 32'(dut_strobes - s0), 32'd1);
        release_all();
        wait_phase(0, 100);
        cyc(3);

        // latency, row 0001 col 0001
        s0 = dut_strobes;
        press(0, 4'b0001, 4'b0001);
        lat_exp = (SCAN_DIV - pcnt) + (3 + DEBOUNCE) * SCAN_DIV;
        n = 0;
        while (!cod_valid && n < 200) begin @(negedge clk); n++; end
        check("lat_cycles", 32'(n), 32'(lat_exp));
        check("lat_cod", 32'(cod), 32'h11);
        cyc(1);
        check("lat_single", 32'(cod_valid), 32'd0);
        cyc(30);
        check("lat_strobes", 32'(dut_strobes - s0), 32'd1);
        release_all();
        wait_phase(0, 100);
        cyc(3);

        // bounce during debounce
        s0 = dut_strobes;
        press(0, 4'b1000, 4'b0100);
        wait_phase(2, 60);
        release_all();
        cyc(30);
        check("bounce_strobes", 32'(dut_strobes - s0), 32'd0);
        check("bounce_cod", 32'(cod), 32'h11);
        check("bounce_fila", 32'(Fila), 32'hF);

        // multi-key pattern in idle is ignored
        s0 = dut_strobes;
        ov_en = 1'b1; ov_col = 4'b0110;
        cyc(40);
        check("multi_fila", 32'(Fila), 32'hF);
        check("multi_strobes", 32'(dut_strobes - s0), 32'd0);

        // column seen only in idle: full walk and back
        ov_col = 4'b0001;
        wait_phase(1, 20);
        ov_col = 4'b0000;
        wait_phase(0, 100);
        check("glitch_strobes", 32'(dut_strobes - s0), 32'd0);
        ov_en = 1'b0;
        cyc(3);

        // release debounce with a bounce, then a fresh key
        press(0, 4'b0010, 4'b1000);
        wait_phase(3, 80);
        ov_en = 1'b1;
        ov_col = 4'b0000; wait_ticks(1);
        ov_col = 4'b0010; wait_ticks(1);
        ov_col = 4'b0000; wait_ticks(1);
        ov_col = 4'b0000; wait_ticks(1);
        check("rel_kd_mid", 32'(key_down), 32'd1);
        ov_col = 4'b0000; wait_ticks(1);
        check("rel_kd_low", 32'(key_down), 32'd0);
        ov_en = 1'b0;
        release_all();
        cyc(3);
        s0 = dut_strobes;
        press(0, 4'b1000, 4'b0001);
        cyc(40);
        check("second_cod", 32'(cod), 32'h81);
        check("second_strobes", 32'(dut_strobes - s0), 32'd1);
        release_all();
        wait_phase(0, 100);

        // randomized presses, occasional second key and short bounces
        for (int it = 0; it < 25; it++) begin
          r = 4'b0001 << $urandom_range(3);
          c = 4'b0001 << $urandom_range(3);
          press(0, r, c);
          cyc($urandom_range(60, 4));
          if ($urandom_range(3) == 0) begin
            r2 = 4'b0001 << $urandom_range(3);
            c2 = 4'b0001 << $urandom_range(3);
            press(1, r2, c2);
            cyc($urandom_range(20, 2));
          end
          release_all();
          cyc($urandom_range(40, 5));
          wait_phase(0, 200);
        end
        cyc(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    join
  end

endmodule

// File: doc/escaner_filas.md
Name: escaner_filas

Overview:
- Row-driving side of the 4x4 matrix keypad interface.
- Drives `Fila` (all rows high while idle, then a one-hot walk) and samples `Columna`.
- Debounces both press and release, then emits one 8-bit key code `{Fila,Columna}` per press with a single-cycle strobe.
- Sits between the keypad pins and the keypad code-to-ASCII decoder. Its `Fila` output is the decoder's row input.

Parameters:
- SCAN_DIV, 1000: `clk_Teclado` cycles per scan tick. Legal range ≥2.
- DEBOUNCE, 4: consecutive matching ticks required to accept a press or a release. Legal range 1..15.

Ports:
- clk_Teclado  in   1  system clock, rising edge.
- rst_n        in   1  asynchronous reset, active-low.
- Columna      in   4  column sense lines, active-high; one-hot when a key in a driven row is pressed.
- Fila         out  4  row drive: 1111 idle, otherwise one-hot 1000/0100/0010/0001.
- cod          out  8  last accepted key code `{row,col}`; holds its value until the next accept.
- cod_valid    out  1  one-cycle strobe when `cod` updates.
- key_down     out  1  high from accept until the release is debounced.

Behaviour:
- Reset, asynchronous: `Fila`=1111, `cod`=0, `cod_valid`=0, `key_down`=0, state=IDLE, prescaler=0, counters=0.
- Reset asserted mid-operation aborts any scan or hold immediately. No strobe is issued.
- Tick generation:
  - Free-running prescaler counts 0..SCAN_DIV-1.
  - `tick`=1 in the cycle the count equals SCAN_DIV-1.
  - All transitions below happen only on `tick`, except EMIT.
- "One-hot" means exactly one bit set. 0000 and any multi-bit pattern are not one-hot.
- IDLE:
  - `Fila`=1111.
  - On tick with `Columna` one-hot: go to SCAN with `Fila`=1000.
  - Otherwise stay in IDLE. Multi-key patterns are ignored.
- SCAN, on each tick:
  - `Columna` one-hot: latch `row`=`Fila` and `col`=`Columna`, set `cnt`=1, go to DEB. If DEBOUNCE=1, go to EMIT instead.
  - Else if `Fila`==0001: return to IDLE (glitch, no key found).
  - Else shift `Fila` right by one.
- DEB (`Fila` held at `row`), on each tick:
  - `Columna`==`col`: `cnt`+1; when `cnt` reaches DEBOUNCE, go to EMIT.
  - Any other value: return to IDLE with no strobe.
- EMIT, exactly one clock, independent of tick:
  - `cod`<=`{row,col}`, `cod_valid`=1, `key_down`=1.
  - Next state is HOLD with `rcnt`=0.
- HOLD (`Fila` held at `row`, `key_down`=1), on each tick:
  - `Columna`==0000: `rcnt`+1.
  - Otherwise: `rcnt`=0.
  - When `rcnt` reaches DEBOUNCE: go to IDLE with `key_down`=0.
  - A second key pressed during HOLD is never reported.
- `cod_valid` is registered and never high for two consecutive cycles.
- Latency: with the key held before detect tick T0 and located in row index r (0 for 1000 .. 3 for 0001), `cod_valid` is high in the cycle after tick T0+r+DEBOUNCE.
- Widths:
  - `cnt` and `rcnt` are 4 bits and saturate at DEBOUNCE.
  - Prescaler width is $clog2(SCAN_DIV).

Test Plan:
- All tests use SCAN_DIV=4 and DEBOUNCE=3 unless stated.
- Reset: assert `rst_n`=0 asynchronously mid-SCAN -> same cycle `Fila`=1111, `cod_valid`=0, `key_down`=0; `cod`=00; after release the next detect restarts from IDLE.
- Clean press: model key at row 0100 / col 0010, held 40 cycles -> `Fila` walks 1111→1000→0100 and then holds; single `cod_valid` pulse; `cod`=8'b01000010; `key_down`=1 until 3 ticks after release, then `Fila`=1111.
- Row 0001 latency: key row 0001 / col 0001 present before tick T0 -> `cod_valid` in the cycle after tick T0+6; `cod`=8'h11; exactly one pulse.
- Bounce: column 0100 present for 1 tick during DEB, then 0000 -> return to IDLE, no `cod_valid`, `cod` unchanged.
- Glitch / multi-key:
  - `Columna`=0110 in IDLE -> stays IDLE with `Fila`=1111.
  - Column active only during IDLE, gone during SCAN -> full walk to 0001, back to IDLE, no strobe.
- Release debounce: in HOLD, `Columna` toggles 0000/0010/0000/0000/0000 on successive ticks -> `key_down` drops only after the final three 0000 ticks; a second press afterwards produces a new strobe with the new code.
